driver_bbm_seq: RTL and testbench

Synchronous break-before-make sequencer for the half-bridge driver loop. Converts the asynchronous `topstate`/`botstate` phase requests into non-overlapping `topswon`/`botswon` gate commands. Adds programmable dead time, minimum on-time with leading-edge blanking, peak-current cut-off and gate-status timeout faults. Sits between the loop's PWM logic and the top/bottom switch cells, which return `topswstatus`/`botswstatus`, `topswipeak` and `botswzcross`.

---
 rtl/driver_bbm_pkg.sv | 28 ++
 rtl/driver_sync.sv | 23 ++
 rtl/driver_bbm_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_driver_bbm_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_bbm_pkg.sv
// Shared types and constants for the half-bridge break-before-make sequencer.
package driver_bbm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDeadT,
    StDeadB,
    StTopOn,
    StBotOn,
    StOffT,
    StOffB,
    StFault
  } bbm_state_t;

  localparam logic [1:0] FaultNone = 2'b00;
  localparam logic [1:0] FaultTop  = 2'b01;
  localparam logic [1:0] FaultBot  = 2'b10;
  localparam logic [1:0] FaultBoth = 2'b11;

  localparam int unsigned SyncStagesDefault = 2;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/driver_sync.sv
// N-stage flop synchronizer for a single asynchronous input, async active-low reset.
module driver_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[Stages-2:0], d};
    end
  end

  assign q = ff_q[Stages-1];

endmodule

// File: rtl/driver_bbm_seq.sv
// Break-before-make gate sequencer with dead time, min on-time/blanking and stuck-switch faults.
// Optional diode-emulation zero-cross exit on the bottom switch: define DRIVER_ZCROSS_EN.
module driver_bbm_seq
  import driver_bbm_pkg::*;
#(
  parameter int unsigned DT_W        = 6,
  parameter int unsigned TMIN_W      = 8,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_driver,
  input  logic              ok_driver,
  input  logic              topstate,
  input  logic              botstate,
  input  logic              topswstatus,
  input  logic              botswstatus,
  input  logic              topswipeak,
  input  logic              botswzcross,
  input  logic [DT_W-1:0]   cfg_dt,
  input  logic [TMIN_W-1:0] cfg_tmin,
  input  logic [TO_W-1:0]   cfg_to,
  output logic              topswon,
  output logic              botswon,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [2:0]        seq_state
);

  localparam int unsigned CntW = max3(DT_W, TMIN_W, TO_W);

`ifdef DRIVER_ZCROSS_EN
  localparam int unsigned NumIn = 8;
`else
  localparam int unsigned NumIn = 7;
`endif

  logic [NumIn-1:0] async_in, sync_in;
  logic enable_s, ok_s, top_s, bot_s, topsw_s, botsw_s, ipeak_s;

`ifdef DRIVER_ZCROSS_EN
  logic zcross_s;
  assign async_in = {botswzcross, topswipeak, botswstatus, topswstatus,
                     botstate, topstate, ok_driver, enable_driver};
  assign zcross_s = sync_in[7];
`else
  logic unused_zcross;
  assign async_in = {topswipeak, botswstatus, topswstatus,
                     botstate, topstate, ok_driver, enable_driver};
  assign unused_zcross = botswzcross;
`endif

  assign {ipeak_s, botsw_s, topsw_s, bot_s, top_s, ok_s, enable_s} = sync_in[6:0];

  for (genvar i = 0; i < NumIn; i++) begin : g_sync
    driver_sync #(
      .Stages(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (async_in[i]),
      .q    (sync_in[i])
    );
  end

  bbm_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic            pk_lock_q, pk_lock_d;
  logic            top_q, bot_q, fault_q;
`ifdef DRIVER_ZCROSS_EN
  logic            zc_lock_q, zc_lock_d;
`endif

  logic            go, top_req, bot_req, top_ok, bot_ok, tmin_done;
  logic [CntW-1:0] dt_load, to_load, cnt_inc, cnt_dec;

  assign go        = enable_s & ok_s;
  assign top_req   = top_s & ~bot_s;
  assign bot_req   = bot_s & ~top_s;
  assign top_ok    = go & top_req & ~pk_lock_q;
`ifdef DRIVER_ZCROSS_EN
  assign bot_ok    = go & bot_req & ~zc_lock_q;
`else
  assign bot_ok    = go & bot_req;
`endif
  assign dt_load   = CntW'(cfg_dt);
  assign to_load   = CntW'(cfg_to);
  assign tmin_done = (cnt_q >= CntW'(cfg_tmin));
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
  assign cnt_dec   = (cnt_q == '0) ? cnt_q : cnt_q - CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    // Locks release once the requesting phase input has been seen low.
    pk_lock_d = pk_lock_q & top_s;
`ifdef DRIVER_ZCROSS_EN
    zc_lock_d = zc_lock_q & bot_s;
`endif
    case (state_q)
      StIdle: begin
        if (top_ok && !botsw_s) begin
          state_d = StDeadT;
          cnt_d   = dt_load;
        end else if (bot_ok && !topsw_s) begin
          state_d = StDeadB;
          cnt_d   = dt_load;
        end
      end
      StDeadT: begin
        if (!top_ok) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StTopOn;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StDeadB: begin
        if (!bot_ok) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StBotOn;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StTopOn: begin
        if (!go) begin
          state_d = StOffT;
          cnt_d   = to_load;
        end else if (tmin_done && (!top_req || ipeak_s)) begin
          state_d = StOffT;
          cnt_d   = to_load;
          if (top_req) pk_lock_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StBotOn: begin
        if (!go || (tmin_done && !bot_req)) begin
          state_d = StOffB;
          cnt_d   = to_load;
`ifdef DRIVER_ZCROSS_EN
        end else if (tmin_done && zcross_s) begin
          state_d   = StOffB;
          cnt_d     = to_load;
          zc_lock_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StOffT: begin
        if (!topsw_s) begin
          state_d = StIdle;
          if (bot_ok) begin
            state_d = StDeadB;
            cnt_d   = dt_load;
          end
        end else if (cnt_q <= CntW'(1)) begin
          // A zero timeout still allows the one OFF cycle before faulting.
          state_d = StFault;
          code_d  = FaultTop;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StOffB: begin
        if (!botsw_s) begin
          state_d = StIdle;
          if (top_ok) begin
            state_d = StDeadT;
            cnt_d   = dt_load;
          end
        end else if (cnt_q <= CntW'(1)) begin
          state_d = StFault;
          code_d  = FaultBot;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StFault: begin
        if (!enable_s && !topsw_s && !botsw_s) begin
          state_d = StIdle;
          code_d  = FaultNone;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (topsw_s && botsw_s && (state_q != StFault)) begin
      state_d = StFault;
      code_d  = FaultBoth;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      code_q    <= FaultNone;
      pk_lock_q <= 1'b0;
      top_q     <= 1'b0;
      bot_q     <= 1'b0;
      fault_q   <= 1'b0;
`ifdef DRIVER_ZCROSS_EN
      zc_lock_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      pk_lock_q <= pk_lock_d;
      top_q     <= (state_d == StTopOn);
      bot_q     <= (state_d == StBotOn);
      fault_q   <= (state_d == StFault);
`ifdef DRIVER_ZCROSS_EN
      zc_lock_q <= zc_lock_d;
`endif
    end
  end

  assign topswon    = top_q & ~bot_q;
  assign botswon    = bot_q & ~top_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_driver_bbm_seq.sv
// Directed bench for driver_bbm_seq: latency table plus hand-written multi-cycle sequences.
module tb_driver_bbm_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_driver, ok_driver, topstate, botstate;
  logic       topswstatus, botswstatus, topswipeak, botswzcross;
  logic [5:0] cfg_dt;
  logic [7:0] cfg_tmin, cfg_to;
  logic       topswon, botswon, fault;
  logic [1:0] fault_code;
  logic [2:0] seq_state;

  // Switch-cell model: status follows the gate with a 3-cycle lag, force bits hold it high.
  logic [2:0] top_sh = '0;
  logic [2:0] bot_sh = '0;
  logic       top_force, bot_force;

  always @(posedge clk) begin
    top_sh <= {top_sh[1:0], topswon};
    bot_sh <= {bot_sh[1:0], botswon};
  end

  assign topswstatus = top_force | top_sh[2];
  assign botswstatus = bot_force | bot_sh[2];

  always #5 clk = ~clk;

  driver_bbm_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_driver(enable_driver),
    .ok_driver    (ok_driver),
    .topstate     (topstate),
    .botstate     (botstate),
    .topswstatus  (topswstatus),
    .botswstatus  (botswstatus),
    .topswipeak   (topswipeak),
    .botswzcross  (botswzcross),
    .cfg_dt       (cfg_dt),
    .cfg_tmin     (cfg_tmin),
    .cfg_to       (cfg_to),
    .topswon      (topswon),
    .botswon      (botswon),
    .fault        (fault),
    .fault_code   (fault_code),
    .seq_state    (seq_state)
  );

  int passed  = 0;
  int total   = 0;
  int overlap = 0;

  typedef struct {
    bit bot;
    int dt;
    int tmin;
    int exp_on;
    int exp_off;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (topswon && botswon) overlap++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns max_cyc+1 if the gate never reaches the level.
  task automatic wait_gate(input bit bot, input bit level, input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((bot ? botswon : topswon) != level) && n <= max_cyc);
  endtask

  initial begin
    int n, g, cnt;

    vecs[0] = '{0, 4, 10, 8, 3};
    vecs[1] = '{0, 0, 2, 4, 3};
    vecs[2] = '{1, 7, 5, 11, 3};
    vecs[3] = '{1, 1, 0, 5, 3};
    vecs[4] = '{0, 63, 3, 67, 3};

    rst_n = 1'b0;
    enable_driver = 1'b1; ok_driver = 1'b1;
    topstate = 1'b0; botstate = 1'b0;
    topswipeak = 1'b0; botswzcross = 1'b0;
    top_force = 1'b0; bot_force = 1'b0;
    cfg_dt = 6'd4; cfg_tmin = 8'd10; cfg_to = 8'd20;

    ticks(3);
    check("reset topswon", int'(topswon), 0);
    check("reset botswon", int'(botswon), 0);
    check("reset fault", int'(fault), 0);
    check("reset fault_code", int'(fault_code), 0);
    check("reset seq_state", int'(seq_state), 0);
    rst_n = 1'b1;
    ticks(3);

    // On latency = SYNC_STAGES + dt + 2, off latency = SYNC_STAGES + 1.
    for (int i = 0; i < 5; i++) begin
      cfg_dt = 6'(vecs[i].dt);
      cfg_tmin = 8'(vecs[i].tmin);
      if (vecs[i].bot) botstate = 1'b1; else topstate = 1'b1;
      wait_gate(vecs[i].bot, 1'b1, 100, n);
      check($sformatf("vec%0d on latency", i), n, vecs[i].exp_on);
      ticks(vecs[i].tmin + 4);
      topstate = 1'b0; botstate = 1'b0;
      wait_gate(vecs[i].bot, 1'b0, 20, n);
      check($sformatf("vec%0d off latency", i), n, vecs[i].exp_off);
      ticks(10);
      check($sformatf("vec%0d back to idle", i), int'(seq_state), 0);
    end

    // Top for 30 cycles, then bottom: top gate width = 30 - 8 + 3.
    cfg_dt = 6'd4; cfg_tmin = 8'd10;
    cnt = 0;
    topstate = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (topswon) cnt++;
    end
    topstate = 1'b0; botstate = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (topswon) cnt++;
    end while (topswstatus && n <= 20);
    check("handover top width", cnt, 25);
    g = 0;
    while (!botswon && g <= 40) begin
      tick();
      g++;
    end
    check("handover gap >= dt+1", int'(g >= 5), 1);
    check("handover bot on", int'(botswon), 1);
    ticks(30);
    botstate = 1'b0;
    wait_gate(1'b1, 1'b0, 20, n);
    ticks(12);
    check("handover idle", int'(seq_state), 0);

    // Peak at cycle 3 of TOP_ON is blanked; gate stays on through count == tmin.
    cfg_dt = 6'd2; cfg_tmin = 8'd10;
    topstate = 1'b1;
    wait_gate(1'b0, 1'b1, 40, n);
    cnt = 1;
    ticks(3);
    cnt += 3;
    topswipeak = 1'b1;
    while (topswon && cnt <= 40) begin
      tick();
      if (topswon) cnt++;
    end
    check("peak blanked on width", cnt, 11);
    topswipeak = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (topswon) cnt++;
    end
    check("peak lock no re-entry", cnt, 0);
    topstate = 1'b0;
    ticks(5);
    topstate = 1'b1;
    wait_gate(1'b0, 1'b1, 40, n);
    check("peak lock re-entry latency", n, 6);
    topstate = 1'b0;
    wait_gate(1'b0, 1'b0, 30, n);
    ticks(12);

    // Bottom stuck on: 8 OFF cycles then FAULT code 10.
    cfg_dt = 6'd2; cfg_tmin = 8'd2; cfg_to = 8'd8;
    botstate = 1'b1;
    wait_gate(1'b1, 1'b1, 40, n);
    ticks(5);
    bot_force = 1'b1;
    botstate = 1'b0;
    wait_gate(1'b1, 1'b0, 20, n);
    n = 0;
    while (!fault && n <= 30) begin
      tick();
      n++;
    end
    check("stuck-off timeout", n, 8);
    check("stuck fault_code", int'(fault_code), 2);
    check("stuck seq_state", int'(seq_state), 7);
    bot_force = 1'b0;
    ticks(8);
    check("fault held while enabled", int'(fault), 1);
    enable_driver = 1'b0;
    ticks(6);
    check("fault cleared", int'(fault), 0);
    check("fault_code cleared", int'(fault_code), 0);
    enable_driver = 1'b1;
    cfg_to = 8'd20;
    ticks(4);

    // Both status high outranks everything.
    top_force = 1'b1; bot_force = 1'b1;
    ticks(4);
    check("both-status fault", int'(fault), 1);
    check("both-status code", int'(fault_code), 3);
    top_force = 1'b0; bot_force = 1'b0;
    enable_driver = 1'b0;
    ticks(6);
    check("both-status cleared", int'(seq_state), 0);
    enable_driver = 1'b1;
    ticks(4);

    // Loss of ok_driver overrides minimum on-time.
    cfg_dt = 6'd1; cfg_tmin = 8'd10;
    topstate = 1'b1;
    wait_gate(1'b0, 1'b1, 40, n);
    ticks(2);
    ok_driver = 1'b0;
    wait_gate(1'b0, 1'b0, 20, n);
    check("ok loss gate-off latency", n, 3);
    ok_driver = 1'b1; topstate = 1'b0;
    ticks(12);
    check("ok loss no fault", int'(fault), 0);

    // Zero-cross exit from BOT_ON.
    cfg_tmin = 8'd4;
    botstate = 1'b1;
    wait_gate(1'b1, 1'b1, 40, n);
    ticks(8);
    botswzcross = 1'b1;
`ifdef DRIVER_ZCROSS_EN
    wait_gate(1'b1, 1'b0, 20, n);
    check("zcross exit latency", n, 3);
    botswzcross = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (botswon) cnt++;
    end
    check("zcross no re-entry", cnt, 0);
`else
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (botswon) cnt++;
    end
    check("zcross ignored", cnt, 10);
    botswzcross = 1'b0;
    check("zcross still on", int'(botswon), 1);
`endif
    botstate = 1'b0;
    ticks(15);
    check("zcross idle", int'(seq_state), 0);

    // Asynchronous reset in TOP_ON.
    topstate = 1'b1;
    wait_gate(1'b0, 1'b1, 40, n);
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset topswon", int'(topswon), 0);
    check("async reset botswon", int'(botswon), 0);
    check("async reset fault", int'(fault), 0);
    check("async reset seq_state", int'(seq_state), 0);
    topstate = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    check("no gate overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
